input_debouncer: RTL and testbench
==================================

# input_debouncer

Synchronizes and debounces the DE1-SoC pushbuttons (KEY[3:0], active-low) and slider switches (SW[9:0]) before they drive `pushbuttons_export` / `slider_switches_export` on Computer_System. Each bit is a raw asynchronous pin. Each bit gets a 2-flop synchronizer, polarity normalization and a per-bit stability counter. The block outputs a clean active-high level plus single-cycle rise/fall pulses. One instance is used per input group.

## Interface
- `WIDTH`, 4: number of independent input bits.
- `STABLE_CYCLES`, 50000: consecutive cycles a new value must persist before it is accepted. The default is 1 ms at 50 MHz. Legal range is ≥ 2.
- `ACTIVE_LOW`, 1: 1 = raw pin inverted (KEY), 0 = raw pin passed through (SW).
- `clk`  in  1  system clock (50 MHz domain of `system_pll_ref_clk_clk`).
- `reset`  in  1  synchronous, active-high reset.
- `raw_in`  in  WIDTH  asynchronous pin inputs.
- `level`  out  WIDTH  debounced, active-high (1 = pressed/on); drives the PIO export.
- `rise`  out  WIDTH  1-cycle pulse on the cycle `level[i]` goes 0→1.
- `fall`  out  WIDTH  1-cycle pulse on the cycle `level[i]` goes 1→0.
- `any_rise`  out  1  OR-reduction of `rise`, registered with it (same cycle).

## Operation
- Normalize: `n = ACTIVE_LOW ? ~raw_in : raw_in`. The inversion happens before the first flop.
- Synchronizer: two flops per bit, `s1 <= n`, `s2 <= s1`. Only `s2` is used downstream.
- Per-bit counter `cnt[i]` is `$clog2(STABLE_CYCLES)` bits wide and unsigned. All bits are processed in parallel and independently.
- Per bit, each cycle:
  - If `s2[i] == level[i]`, then `cnt[i] <= 0`. This is the idle state: a glitch shorter than the window resets it.
  - Else if `cnt[i] == STABLE_CYCLES-1`, then `level[i] <= s2[i]`, `cnt[i] <= 0`, and `rise[i]`/`fall[i]` is asserted per direction.
  - Else `cnt[i] <= cnt[i]+1`.
- Per-bit states are implicit: STABLE (`cnt==0`, `s2==level`) and PENDING (`s2!=level`). PENDING returns to STABLE either on acceptance or on the input reverting.
- The counter never wraps. It is cleared on the acceptance cycle, before it can exceed `STABLE_CYCLES-1`.
- `rise` and `fall` are registered. They are never both high for the same bit. They are high for exactly one cycle per accepted change.
- Simultaneous changes on several bits are accepted independently. Several `rise` bits may assert in the same cycle.
- Reset:
  - `s1`, `s2`, `level`, `cnt`, `rise`, `fall` and `any_rise` are all cleared to 0. For `s1`/`s2` this is the normalized value, so released buttons cause no spurious edge after reset.
  - Reset asserted mid-PENDING discards the pending change.
  - After reset release, a still-changed input is re-qualified from `cnt=0`. A button held through reset therefore produces a `rise` after the full latency.

## Timing
- Latency from a raw pin change (setting up before edge 0) to `level` updating is STABLE_CYCLES+2 clock edges:
  - edges 0–1 are the synchronizer;
  - edges 2..STABLE_CYCLES+1 are STABLE_CYCLES consecutive differing samples.
- `rise`/`fall` are high during the same cycle that `level` first shows the new value. They drop on the next edge.
- Minimum accepted pulse width is STABLE_CYCLES cycles at `s2`. Any shorter excursion is fully rejected, producing no `level` change and no pulse.
- Maximum toggle rate is one accepted change per STABLE_CYCLES cycles per bit.
- All outputs are registered; there are no combinational paths from `raw_in`.

## Test plan
All scenarios use STABLE_CYCLES=4, WIDTH=4, ACTIVE_LOW=1.
- Reset with `raw_in=4'hF`, held 10 cycles, then deasserted → `level=0`, `rise=fall=0` throughout, and no pulse after release.
- Press: `raw_in[0]` 1→0 before edge 0 and held → `level[0]=1` and `rise[0]=1` in the cycle after edge 5. `rise[0]=0` after edge 6. Other bits stay 0.
- Bounce: `raw_in[1]` low for 3 cycles, high for 1, then low for 3 → no change, because each run is under 4 samples. Then held low → `level[1]=1` exactly 6 edges after the final falling transition.
- Release: with `level[2]=1`, `raw_in[2]` goes 0→1 and is held → `fall[2]=1`, and `level[2]=0` 6 edges later. `rise[2]` stays 0.
- Simultaneous: `raw_in` 4'hF→4'h0 in one cycle → `rise=4'hF` and `any_rise=1` in the same single cycle, and `level=4'hF`.
- Reset mid-PENDING: `raw_in[3]` low for 3 cycles, then `reset` for 1 cycle with the pin held low → first `rise[3]` occurs 6 edges after reset deassertion. It does not occur at the originally pending point.

Source files
------------

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Synchronizes and debounces a group of raw asynchronous board inputs
// (pushbuttons or slider switches). Each bit is polarity-normalized,
// passed through a two-flop synchronizer and then qualified by its own
// stability counter. A new value must be seen for STABLE_CYCLES
// consecutive cycles before it is accepted onto the output level.
//
// Parameters:
//   WIDTH          number of independent input bits
//   STABLE_CYCLES  consecutive cycles a new value must persist (>= 2)
//   ACTIVE_LOW     1 = raw pin inverted (buttons), 0 = passed through
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   raw_in    in   [WIDTH-1:0] asynchronous pin inputs
//   level     out  [WIDTH-1:0] debounced level, 1 = pressed/on
//   rise      out  [WIDTH-1:0] one-cycle pulse when level[i] goes 0->1
//   fall      out  [WIDTH-1:0] one-cycle pulse when level[i] goes 1->0
//   any_rise  out  OR of rise, aligned with it
// -----------------------------------------------------------------------------
module input_debouncer #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 50000,
   parameter int ACTIVE_LOW    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             any_rise
);

   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] norm_in;
   logic [WIDTH-1:0] s1_reg;
   logic [WIDTH-1:0] s2_reg;
   logic [WIDTH-1:0] rise_next_vec;
   logic             any_rise_reg;

   // Inversion sits in front of the first flop so reset value 0 of the
   // synchronizer matches a released button and no edge follows reset.
   assign norm_in = (ACTIVE_LOW != 0) ? ~raw_in : raw_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_reg <= '0;
         s2_reg <= '0;
      end else begin
         s1_reg <= norm_in;
         s2_reg <= s1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic             level_reg;
         logic             level_next;
         logic             rise_reg;
         logic             rise_next;
         logic             fall_reg;
         logic             fall_next;

         // Counter only runs while the synchronized input disagrees with
         // the accepted level; any agreeing sample restarts qualification.
         always_comb begin
            cnt_next   = cnt_reg;
            level_next = level_reg;
            rise_next  = 1'b0;
            fall_next  = 1'b0;
            if (s2_reg[gi] == level_reg) begin
               cnt_next = '0;
            end else if (cnt_reg == CNT_MAX) begin
               level_next = s2_reg[gi];
               cnt_next   = '0;
               rise_next  = s2_reg[gi];
               fall_next  = ~s2_reg[gi];
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_reg   <= '0;
               level_reg <= 1'b0;
               rise_reg  <= 1'b0;
               fall_reg  <= 1'b0;
            end else begin
               cnt_reg   <= cnt_next;
               level_reg <= level_next;
               rise_reg  <= rise_next;
               fall_reg  <= fall_next;
            end
         end

         assign rise_next_vec[gi] = rise_next;
         assign level[gi]         = level_reg;
         assign rise[gi]          = rise_reg;
         assign fall[gi]          = fall_reg;
      end
   endgenerate

   // Registered from the same next-state terms so it lines up with rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         any_rise_reg <= 1'b0;
      end else begin
         any_rise_reg <= |rise_next_vec;
      end
   end

   assign any_rise = any_rise_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer with WIDTH=4, STABLE_CYCLES=4,
// ACTIVE_LOW=1. A behavioural model tracks, per bit, the input as seen
// two clock edges late and how many consecutive samples have disagreed
// with the accepted level; outputs are compared every cycle. Directed
// scenarios add literal expectations at the cycles of interest.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

   localparam int W  = 4;
   localparam int SC = 4;

   logic         clk;
   logic         reset;
   logic [W-1:0] raw_in;
   logic [W-1:0] level;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic         any_rise;

   int tests_run;
   int tests_failed;
   int cyc;

   input_debouncer #(
      .WIDTH        (W),
      .STABLE_CYCLES(SC),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .raw_in  (raw_in),
      .level   (level),
      .rise    (rise),
      .fall    (fall),
      .any_rise(any_rise)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests_run = tests_run + 1;
      if (got !== exp) begin
         tests_failed = tests_failed + 1;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] hist1;      // input as seen one edge ago
   logic [W-1:0] hist2;      // input as seen two edges ago (what is judged)
   logic [W-1:0] m_level;
   logic [W-1:0] m_rise;
   logic [W-1:0] m_fall;
   logic         m_any;
   int           m_run[W];
   bit           m_valid;

   initial begin
      m_valid = 1'b0;
      hist1 = '0; hist2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_valid = 1'b1;
            hist1 = '0; hist2 = '0; m_level = '0;
            m_rise = '0; m_fall = '0; m_any = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
         end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
               if (hist2[i] != m_level[i]) begin
                  m_run[i] = m_run[i] + 1;
                  if (m_run[i] == SC) begin
                     m_level[i] = hist2[i];
                     if (hist2[i]) m_rise[i] = 1'b1;
                     else          m_fall[i] = 1'b1;
                     m_run[i] = 0;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
            m_any = |m_rise;
            hist2 = hist1;
            hist1 = ~raw_in;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         if (m_valid) begin
            chk("model_level", level, m_level);
            chk("model_rise", rise, m_rise);
            chk("model_fall", fall, m_fall);
            chk("model_any_rise", {3'b000, any_rise}, {3'b000, m_any});
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset  = 1'b1;
      raw_in = 4'hF;

      // Reset with all buttons released
      wait_cycles(10);
      chk("reset_level", level, 4'h0);
      chk("reset_rise", rise, 4'h0);
      chk("reset_fall", fall, 4'h0);
      reset = 1'b0;
      $display("[TB] reset released, raw_in=%h", raw_in);
      for (int k = 0; k < 8; k++) begin
         wait_cycles(1);
         chk("post_reset_rise", rise, 4'h0);
         chk("post_reset_level", level, 4'h0);
      end

      // Press bit 0
      raw_in = 4'hE;
      wait_cycles(5);
      chk("press_level_early", level, 4'h0);
      wait_cycles(1);
      chk("press_level", level, 4'h1);
      chk("press_rise", rise, 4'h1);
      chk("press_any_rise", {3'b000, any_rise}, 4'h1);
      wait_cycles(1);
      chk("press_rise_drop", rise, 4'h0);
      $display("[TB] press bit0: level=%h", level);

      // Bounce on bit 1: low 3, high 1, then low and held
      raw_in = 4'hC;
      wait_cycles(3);
      raw_in = 4'hE;
      wait_cycles(1);
      raw_in = 4'hC;
      wait_cycles(5);
      chk("bounce_level_held", level, 4'h1);
      wait_cycles(1);
      chk("bounce_level", level, 4'h3);
      chk("bounce_rise", rise, 4'h2);
      $display("[TB] bounce bit1: level=%h", level);

      // Release bit 2 after it has been accepted as pressed
      raw_in = 4'h8;
      wait_cycles(10);
      chk("bit2_pressed", level, 4'h7);
      raw_in = 4'hC;
      wait_cycles(5);
      chk("release_level_early", level, 4'h7);
      wait_cycles(1);
      chk("release_level", level, 4'h3);
      chk("release_fall", fall, 4'h4);
      chk("release_rise", rise, 4'h0);
      $display("[TB] release bit2: level=%h", level);

      // Simultaneous press on all bits from fully released
      raw_in = 4'hF;
      wait_cycles(10);
      chk("all_released", level, 4'h0);
      raw_in = 4'h0;
      wait_cycles(6);
      chk("simul_rise", rise, 4'hF);
      chk("simul_any_rise", {3'b000, any_rise}, 4'h1);
      chk("simul_level", level, 4'hF);
      wait_cycles(1);
      chk("simul_rise_drop", rise, 4'h0);
      chk("simul_any_drop", {3'b000, any_rise}, 4'h0);
      $display("[TB] simultaneous press: level=%h", level);
      raw_in = 4'hF;
      wait_cycles(10);
      chk("simul_release", level, 4'h0);

      // Reset while bit 3 is pending
      raw_in = 4'h7;
      wait_cycles(3);
      reset = 1'b1;
      wait_cycles(1);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         wait_cycles(1);
         chk("midreset_no_rise", rise, 4'h0);
         chk("midreset_level", level, 4'h0);
      end
      wait_cycles(1);
      chk("midreset_rise", rise, 4'h8);
      chk("midreset_level_set", level, 4'h8);
      $display("[TB] reset mid-pending: level=%h", level);

      wait_cycles(3);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
